inst_rf_scoreboard: RTL and testbench
=====================================

Name: inst_rf_scoreboard

Overview:
Parametrised successor to the combinational instruction-field extractor. Decodes rs1/rs2/rd plus per-opcode usage flags from a fetched instruction, holds it in a one-entry issue stage, and tracks outstanding register writes per architectural register. Stalls issue on RAW hazards and on write-counter saturation. Sits between fetch and register-file read/execute in the multi-cycle pipeline.

Parameters:
NUM_REGS, 32, number of architectural registers; register 0 is hardwired zero.
REG_AW, 5, register index width; equals clog2(NUM_REGS).
INST_W, 32, instruction width.
CNT_W, 2, width of the per-register pending-write counter; the maximum number of outstanding writes per register is 2^CNT_W-1.
PERF_W, 16, width of the stall performance counter.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  fetch offers an instruction
in_ready  out  1  block accepts the instruction
inst  in  INST_W  instruction word
out_valid  out  1  held instruction is hazard-free and offered to issue
out_ready  in  1  downstream accepts
out_inst  out  INST_W  held instruction
out_rs1, out_rs2, out_rd  out  REG_AW  inst[19:15], inst[24:20], inst[11:7]
out_uses_rs1, out_uses_rs2, out_writes_rd  out  1  decoded usage flags
wb_valid  in  1  writeback retires one write
wb_rd  in  REG_AW  writeback destination
flush  in  1  discard the held instruction
wb_err  out  1  sticky flag: writeback to a register with zero pending writes
stall_cycles  out  PERF_W  saturating count of cycles held due to hazard

Behaviour:
- Reset (rst_n low, asynchronous): stage empty, all counters 0, out_valid=0, in_ready=1, wb_err=0, stall_cycles=0. Held data fields reset to 0.
- Decode by opcode:
  - uses_rs1: ARITH, ADDI, COND_BRA, JALR, LOAD, STORE.
  - uses_rs2: ARITH, COND_BRA, STORE.
  - writes_rd: ARITH, ADDI, JAL, JALR, LOAD, and only when rd!=0.
  - Unknown opcode: all three flags 0; the instruction passes through without hazard checks.
- Stage states:
  - EMPTY: stage holds nothing.
  - HELD: stage holds an instruction with no hazard; out_valid=1.
  - STALLED: stage holds an instruction with a hazard; out_valid=0.
  - State is derived from stage_valid and hazard.
- hazard = (uses_rs1 & rs1!=0 & cnt[rs1]!=0) | (uses_rs2 & rs2!=0 & cnt[rs2]!=0) | (writes_rd & cnt[rd]==max). Counters are read as registered values.
- fire = out_valid & out_ready. in_ready = !stage_valid | fire.
- Load: an accepted instruction enters the stage on the next edge. Latency is 1 cycle minimum from acceptance to out_valid.
- Back-to-back issue: the instruction accepted in the same cycle as a fire is checked against counters that already include the fired write (next-cycle view).
- Counter update each edge:
  - fire & writes_rd increments cnt[rd].
  - wb_valid & wb_rd!=0 & cnt[wb_rd]!=0 decrements cnt[wb_rd].
  - Increment and decrement on the same register in the same cycle leave the count unchanged.
  - wb to register 0 is ignored.
  - wb to a register with cnt=0 leaves the count unchanged and sets wb_err.
- flush: clears stage_valid and forces in_ready=0 for that cycle. Has priority over fire; no counter increments. Counters are untouched because in-flight writes still retire.
- stall_cycles increments each cycle in STALLED and saturates at all-ones.

Optional Feature:
WB_BYPASS_EN:
- Defined: hazard evaluation uses the counter value after this cycle's writeback decrement, so a writeback releases a dependent instruction in the same cycle.
- Undefined: release happens one cycle after the writeback.

Decomposition:
- Shared package/include: opcode constants (ARITH, ADDI, COND_BRA, JAL, JALR, LOAD, STORE) and the stage-state encoding.
- Sub-module inst_decode_flags: combinational field extraction plus usage flags.
- The counter array and stage stay in the top level.

Test Plan:
- Reset, then addi x1,x0,5 (0x00500093) → out_valid 1 cycle after accept, out_rd=1, writes_rd=1; cnt[1]=1 after fire.
- addi x1 fires, then add x3,x1,x2 (0x002081B3) → STALLED, stall_cycles increments. wb_rd=1 → out_valid the next cycle (the same cycle with WB_BYPASS_EN).
- sw x5,0(x6) (0x00532023) → uses_rs1=uses_rs2=1, writes_rd=0, no counter change.
- Issue 3 writes to x4 (CNT_W=2) with no wb, then a fourth sub x4,x3,x1 (0x40118233) → stalls on saturation until one wb_rd=4.
- wb_rd=7 with cnt[7]=0 → wb_err=1 and stays 1; counters unchanged.
- flush during STALLED → stage EMPTY next cycle, no cnt change. Reset asserted mid-stall → all outputs return to reset values immediately.

Source files
------------

// File: rtl/inst_rf_scoreboard_pkg.sv
//------------------------------------------------------------------------------
// inst_rf_scoreboard_pkg
// Opcode constants, decoded usage-flag bundle and issue-stage state encoding.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package inst_rf_scoreboard_pkg;

   localparam logic [6:0] c_opc_arith    = 7'b0110011;
   localparam logic [6:0] c_opc_addi     = 7'b0010011;
   localparam logic [6:0] c_opc_cond_bra = 7'b1100011;
   localparam logic [6:0] c_opc_jal      = 7'b1101111;
   localparam logic [6:0] c_opc_jalr     = 7'b1100111;
   localparam logic [6:0] c_opc_load     = 7'b0000011;
   localparam logic [6:0] c_opc_store    = 7'b0100011;

   localparam logic [1:0] c_st_empty   = 2'd0;
   localparam logic [1:0] c_st_held    = 2'd1;
   localparam logic [1:0] c_st_stalled = 2'd2;

   typedef struct packed {
      logic uses_rs1;
      logic uses_rs2;
      logic writes_rd;
   } dec_flags_t;

   function automatic logic [1:0] stage_state(input logic valid, input logic hazard);
      if (!valid)
         return c_st_empty;
      return hazard ? c_st_stalled : c_st_held;
   endfunction

endpackage

`default_nettype wire

// File: rtl/inst_rf_scoreboard_if.sv
//------------------------------------------------------------------------------
// inst_rf_scoreboard_if
// Fetch, issue and writeback signals of the scoreboard; master drives fetch side.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface inst_rf_scoreboard_if #(
   parameter int INST_W = 32,
   parameter int REG_AW = 5,
   parameter int PERF_W = 16
) ();
   logic              in_valid;
   logic              in_ready;
   logic [INST_W-1:0] inst;
   logic              out_valid;
   logic              out_ready;
   logic [INST_W-1:0] out_inst;
   logic [REG_AW-1:0] out_rs1;
   logic [REG_AW-1:0] out_rs2;
   logic [REG_AW-1:0] out_rd;
   logic              out_uses_rs1;
   logic              out_uses_rs2;
   logic              out_writes_rd;
   logic              wb_valid;
   logic [REG_AW-1:0] wb_rd;
   logic              flush;
   logic              wb_err;
   logic [PERF_W-1:0] stall_cycles;

   modport master (
      output in_valid, inst, out_ready, wb_valid, wb_rd, flush,
      input  in_ready, out_valid, out_inst, out_rs1, out_rs2, out_rd,
             out_uses_rs1, out_uses_rs2, out_writes_rd, wb_err, stall_cycles
   );

   modport slave (
      input  in_valid, inst, out_ready, wb_valid, wb_rd, flush,
      output in_ready, out_valid, out_inst, out_rs1, out_rs2, out_rd,
             out_uses_rs1, out_uses_rs2, out_writes_rd, wb_err, stall_cycles
   );
endinterface

`default_nettype wire

// File: rtl/inst_rf_scoreboard_decode_flags.sv
//------------------------------------------------------------------------------
// inst_decode_flags
// Combinational register-field extraction and per-opcode usage flags.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module inst_decode_flags
   import inst_rf_scoreboard_pkg::*;
#(
   parameter int INST_W = 32,
   parameter int REG_AW = 5
) (
   input  wire logic [INST_W-1:0] inst_i,
   output      logic [REG_AW-1:0] rs1_o,
   output      logic [REG_AW-1:0] rs2_o,
   output      logic [REG_AW-1:0] rd_o,
   output      dec_flags_t        flags_o
);
   logic [6:0] w_opc;
   logic       w_rd_nz;
   logic       w_unused_bits;

   assign w_opc         = inst_i[6:0];
   assign rs1_o         = inst_i[15 +: REG_AW];
   assign rs2_o         = inst_i[20 +: REG_AW];
   assign rd_o          = inst_i[7 +: REG_AW];
   assign w_rd_nz       = (inst_i[7 +: REG_AW] != '0);
   assign w_unused_bits = ^{inst_i[INST_W-1:25], inst_i[14:12]};

   // Unknown opcodes decode to no usage, so they bypass every hazard check.
   always_comb begin
      flags_o = '0;
      case (w_opc)
         c_opc_arith:    flags_o = '{uses_rs1: 1'b1, uses_rs2: 1'b1, writes_rd: w_rd_nz};
         c_opc_addi:     flags_o = '{uses_rs1: 1'b1, uses_rs2: 1'b0, writes_rd: w_rd_nz};
         c_opc_cond_bra: flags_o = '{uses_rs1: 1'b1, uses_rs2: 1'b1, writes_rd: 1'b0};
         c_opc_jal:      flags_o = '{uses_rs1: 1'b0, uses_rs2: 1'b0, writes_rd: w_rd_nz};
         c_opc_jalr:     flags_o = '{uses_rs1: 1'b1, uses_rs2: 1'b0, writes_rd: w_rd_nz};
         c_opc_load:     flags_o = '{uses_rs1: 1'b1, uses_rs2: 1'b0, writes_rd: w_rd_nz};
         c_opc_store:    flags_o = '{uses_rs1: 1'b1, uses_rs2: 1'b1, writes_rd: 1'b0};
         default:        flags_o = '0;
      endcase
   end
endmodule

`default_nettype wire

// File: rtl/inst_rf_scoreboard.sv
//------------------------------------------------------------------------------
// inst_rf_scoreboard
// One-entry issue stage with per-register pending-write counters; stalls on RAW
// hazards and counter saturation. Optional macro WB_BYPASS_EN lets a same-cycle
// writeback release a dependent instruction.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module inst_rf_scoreboard
   import inst_rf_scoreboard_pkg::*;
#(
   parameter int NUM_REGS = 32,
   parameter int REG_AW   = 5,
   parameter int INST_W   = 32,
   parameter int CNT_W    = 2,
   parameter int PERF_W   = 16
) (
   input wire logic            clk,
   input wire logic            rst_n,
   inst_rf_scoreboard_if.slave bus
);
   localparam logic [CNT_W-1:0] c_cnt_max = '1;
   localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

   logic              stage_valid_q, stage_valid_d;
   logic [INST_W-1:0] inst_q, inst_d;
   logic [CNT_W-1:0]  cnt_q [NUM_REGS];
   logic [CNT_W-1:0]  cnt_d [NUM_REGS];
   logic [CNT_W-1:0]  w_cnt_eff [NUM_REGS];
   logic              wb_err_q, wb_err_d;
   logic [PERF_W-1:0] stall_q, stall_d;

   logic [REG_AW-1:0] w_rs1, w_rs2, w_rd;
   dec_flags_t        w_flags;
   logic              w_hazard, w_out_valid, w_fire, w_in_ready, w_accept;
   logic              w_wb_hit, w_wb_zero;
   logic [1:0]        w_state;

   inst_decode_flags #(
      .INST_W (INST_W),
      .REG_AW (REG_AW)
   ) u_dec (
      .inst_i  (inst_q),
      .rs1_o   (w_rs1),
      .rs2_o   (w_rs2),
      .rd_o    (w_rd),
      .flags_o (w_flags)
   );

   assign w_wb_hit  = bus.wb_valid && (bus.wb_rd != '0) && (cnt_q[bus.wb_rd] != '0);
   assign w_wb_zero = bus.wb_valid && (bus.wb_rd != '0) && (cnt_q[bus.wb_rd] == '0);

   // Counter view used by the hazard check: with bypass, this cycle's retire is already applied.
   always_comb begin
      for (int r = 0; r < NUM_REGS; r++) begin
`ifdef WB_BYPASS_EN
         w_cnt_eff[r] = (w_wb_hit && (bus.wb_rd == REG_AW'(r))) ? cnt_q[r] - c_cnt_one : cnt_q[r];
`else
         w_cnt_eff[r] = cnt_q[r];
`endif
      end
   end

   assign w_hazard = (w_flags.uses_rs1  && (w_rs1 != '0) && (w_cnt_eff[w_rs1] != '0))
                  || (w_flags.uses_rs2  && (w_rs2 != '0) && (w_cnt_eff[w_rs2] != '0))
                  || (w_flags.writes_rd && (w_cnt_eff[w_rd] == c_cnt_max));

   assign w_state     = stage_state(stage_valid_q, w_hazard);
   assign w_out_valid = (w_state == c_st_held);
   assign w_fire      = w_out_valid && bus.out_ready && !bus.flush;
   assign w_in_ready  = !bus.flush && ((w_state == c_st_empty) || w_fire);
   assign w_accept    = bus.in_valid && w_in_ready;

   always_comb begin
      stage_valid_d = stage_valid_q;
      inst_d        = inst_q;
      if (bus.flush) begin
         stage_valid_d = 1'b0;
      end else if (w_accept) begin
         stage_valid_d = 1'b1;
         inst_d        = bus.inst;
      end else if (w_fire) begin
         stage_valid_d = 1'b0;
      end
   end

   // Increment and decrement of the same entry cancel out naturally.
   always_comb begin
      for (int r = 0; r < NUM_REGS; r++) begin
         cnt_d[r] = cnt_q[r];
         if (w_fire && w_flags.writes_rd && (w_rd == REG_AW'(r)))
            cnt_d[r] = cnt_d[r] + c_cnt_one;
         if (w_wb_hit && (bus.wb_rd == REG_AW'(r)))
            cnt_d[r] = cnt_d[r] - c_cnt_one;
      end
      cnt_d[0] = '0;
   end

   assign wb_err_d = wb_err_q || w_wb_zero;
   assign stall_d  = ((w_state == c_st_stalled) && (stall_q != '1)) ? stall_q + PERF_W'(1) : stall_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage_valid_q <= 1'b0;
         inst_q        <= '0;
         wb_err_q      <= 1'b0;
         stall_q       <= '0;
         for (int r = 0; r < NUM_REGS; r++)
            cnt_q[r] <= '0;
      end else begin
         stage_valid_q <= stage_valid_d;
         inst_q        <= inst_d;
         wb_err_q      <= wb_err_d;
         stall_q       <= stall_d;
         for (int r = 0; r < NUM_REGS; r++)
            cnt_q[r] <= cnt_d[r];
      end
   end

   assign bus.in_ready      = w_in_ready;
   assign bus.out_valid     = w_out_valid;
   assign bus.out_inst      = inst_q;
   assign bus.out_rs1       = w_rs1;
   assign bus.out_rs2       = w_rs2;
   assign bus.out_rd        = w_rd;
   assign bus.out_uses_rs1  = w_flags.uses_rs1;
   assign bus.out_uses_rs2  = w_flags.uses_rs2;
   assign bus.out_writes_rd = w_flags.writes_rd;
   assign bus.wb_err        = wb_err_q;
   assign bus.stall_cycles  = stall_q;
endmodule

`default_nettype wire

// File: tb/tb_inst_rf_scoreboard.sv
//------------------------------------------------------------------------------
// tb_inst_rf_scoreboard
// Directed and random stimulus against a cycle-level reference model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_inst_rf_scoreboard;
   localparam int NR   = 32;
   localparam int AW   = 5;
   localparam int IW   = 32;
   localparam int CW   = 2;
   localparam int PW   = 16;
   localparam int CMAX = (1 << CW) - 1;
   localparam int SMAX = (1 << PW) - 1;
`ifdef WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   inst_rf_scoreboard_if #(.INST_W(IW), .REG_AW(AW), .PERF_W(PW)) bus ();

   inst_rf_scoreboard #(
      .NUM_REGS (NR),
      .REG_AW   (AW),
      .INST_W   (IW),
      .CNT_W    (CW),
      .PERF_W   (PW)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference state: what the stage holds and how many writes are in flight per register.
   bit          m_held;
   logic [31:0] m_inst;
   int          m_cnt [NR];
   bit          m_err;
   int          m_stall;

   function automatic bit [2:0] flags_of(input logic [31:0] i);
      bit w;
      w = (i[11:7] != 5'd0);
      case (i[6:0])
         7'h33:   return {1'b1, 1'b1, w};
         7'h13:   return {1'b1, 1'b0, w};
         7'h63:   return {1'b1, 1'b1, 1'b0};
         7'h6f:   return {1'b0, 1'b0, w};
         7'h67:   return {1'b1, 1'b0, w};
         7'h03:   return {1'b1, 1'b0, w};
         7'h23:   return {1'b1, 1'b1, 1'b0};
         default: return 3'b000;
      endcase
   endfunction

   task automatic model_reset();
      m_held  = 1'b0;
      m_inst  = '0;
      m_err   = 1'b0;
      m_stall = 0;
      for (int r = 0; r < NR; r++) m_cnt[r] = 0;
   endtask

   task automatic drive_idle();
      bus.in_valid  = 1'b0;
      bus.inst      = '0;
      bus.out_ready = 1'b0;
      bus.wb_valid  = 1'b0;
      bus.wb_rd     = '0;
      bus.flush     = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
      check({tag, "_in_ready"},  64'(bus.in_ready),  64'd1);
      check({tag, "_wb_err"},    64'(bus.wb_err),    64'd0);
      check({tag, "_stall"},     64'(bus.stall_cycles), 64'd0);
      check({tag, "_out_inst"},  64'(bus.out_inst),  64'd0);
   endtask

   // One clock: drive after the edge, compare at negedge, advance the model, then cross the edge.
   task automatic step(input bit iv, input logic [31:0] ins, input bit ordy,
                       input bit wv, input logic [4:0] wrd, input bit fl);
      bit [2:0] f;
      int       c [NR];
      bit       hz, ov, fire, ir;
      int       rs1, rs2, rd;
      bus.in_valid  = iv;
      bus.inst      = ins;
      bus.out_ready = ordy;
      bus.wb_valid  = wv;
      bus.wb_rd     = wrd;
      bus.flush     = fl;
      f   = flags_of(m_inst);
      rs1 = int'(m_inst[19:15]);
      rs2 = int'(m_inst[24:20]);
      rd  = int'(m_inst[11:7]);
      for (int r = 0; r < NR; r++)
         c[r] = m_cnt[r] - ((BYP && wv && int'(wrd) == r && r != 0 && m_cnt[r] > 0) ? 1 : 0);
      hz   = (f[2] && rs1 != 0 && c[rs1] > 0) || (f[1] && rs2 != 0 && c[rs2] > 0)
          || (f[0] && c[rd] == CMAX);
      ov   = m_held && !hz;
      fire = ov && ordy && !fl;
      ir   = !fl && (!m_held || fire);
      @(negedge clk);
      check("out_valid", 64'(bus.out_valid), 64'(ov));
      check("in_ready",  64'(bus.in_ready),  64'(ir));
      check("out_inst",  64'(bus.out_inst),  64'(m_inst));
      check("rs_fields", 64'({bus.out_rs1, bus.out_rs2, bus.out_rd}), 64'({m_inst[19:15], m_inst[24:20], m_inst[11:7]}));
      check("flags",     64'({bus.out_uses_rs1, bus.out_uses_rs2, bus.out_writes_rd}), 64'(f));
      check("wb_err",    64'(bus.wb_err),    64'(m_err));
      check("stall_cycles", 64'(bus.stall_cycles), 64'(m_stall));
      if (m_held && hz && m_stall < SMAX) m_stall++;
      if (wv && wrd != 5'd0) begin
         if (m_cnt[wrd] > 0) m_cnt[wrd]--;
         else                m_err = 1'b1;
      end
      if (fire && f[0]) m_cnt[rd]++;
      if (fl)                  m_held = 1'b0;
      else if (iv && ir)       begin m_held = 1'b1; m_inst = ins; end
      else if (fire)           m_held = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 1'b0);
   endtask

   function automatic logic [31:0] rand_inst();
      logic [6:0]  opcs [8];
      logic [31:0] i;
      opcs = '{7'h33, 7'h13, 7'h63, 7'h6f, 7'h67, 7'h03, 7'h23, 7'h0f};
      i        = $urandom;
      i[6:0]   = opcs[$urandom_range(0, 7)];
      i[11:7]  = 5'($urandom_range(0, 7));
      i[19:15] = 5'($urandom_range(0, 7));
      i[24:20] = 5'($urandom_range(0, 7));
      return i;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      drive_idle();
      rst_n = 1'b0;
      model_reset();
      #2;
      check_reset_outputs("reset");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // addi x1 ; add x3,x1,x2 stalls until x1 retires
      step(1'b1, 32'h00500093, 1'b0, 1'b0, 5'd0, 1'b0);
      step(1'b0, 32'h0,        1'b0, 1'b0, 5'd0, 1'b0);
      step(1'b1, 32'h002081B3, 1'b1, 1'b0, 5'd0, 1'b0);
      idle(2);
      step(1'b0, 32'h0, 1'b1, 1'b1, 5'd1, 1'b0);
      idle(1);
      // sw x5,0(x6) while x3 retires
      step(1'b1, 32'h00532023, 1'b1, 1'b0, 5'd0, 1'b0);
      step(1'b0, 32'h0,        1'b1, 1'b1, 5'd3, 1'b0);
      // three writes to x4 then sub x4 stalls on saturation
      for (int k = 0; k < 3; k++) step(1'b1, 32'h00400213, 1'b1, 1'b0, 5'd0, 1'b0);
      step(1'b1, 32'h40118233, 1'b1, 1'b0, 5'd0, 1'b0);
      idle(3);
      step(1'b0, 32'h0, 1'b1, 1'b1, 5'd4, 1'b0);
      idle(2);
      // writeback to a register with nothing pending
      step(1'b0, 32'h0, 1'b1, 1'b1, 5'd7, 1'b0);
      idle(2);
      // flush while stalled, with a competing fetch that must not be taken
      step(1'b1, 32'h40118233, 1'b1, 1'b0, 5'd0, 1'b0);
      idle(2);
      step(1'b1, 32'h00500093, 1'b1, 1'b0, 5'd0, 1'b1);
      idle(2);
      // asynchronous reset in the middle of a stall
      step(1'b1, 32'h40118233, 1'b1, 1'b0, 5'd0, 1'b0);
      idle(2);
      drive_idle();
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midreset");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int k = 0; k < 400; k++) begin
         logic [4:0] wrd;
         bit         wv;
         int         pend [$];
         for (int r = 1; r < 8; r++) if (m_cnt[r] > 0) pend.push_back(r);
         wv  = ($urandom_range(0, 99) < 40);
         wrd = 5'($urandom_range(0, 7));
         if (pend.size() > 0 && $urandom_range(0, 99) < 90)
            wrd = 5'(pend[$urandom_range(0, pend.size() - 1)]);
         step($urandom_range(0, 99) < 70, rand_inst(), $urandom_range(0, 99) < 70,
              wv, wrd, $urandom_range(0, 99) < 4);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

`default_nettype wire
